// File: rtl/clint_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the CLINT timer slice.
package clint_pkg;

  localparam logic [15:0] MSIP_OFS     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] MTIME_OFS    = 16'hBFF8;

  // A compare value of all-ones keeps mtip low until software programs it.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StResp = 1'b1;

  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divider that produces the mtime tick once every 2^TIME_DIV_LOG2 clocks.
module clint_prescaler
  import clint_pkg::*;
#(
  parameter int unsigned TIME_DIV_LOG2 = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TIME_DIV_LOG2 == 0) ? 1 : TIME_DIV_LOG2;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terminal;

  // With no division the counter never leaves 0 and every cycle is terminal.
  assign terminal = (TIME_DIV_LOG2 == 0) ? 1'b1 : (&cnt_q);
  assign tick     = terminal & ~halt;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!halt) begin
      cnt_d = terminal ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// CLINT timer: mtime/mtimecmp/msip registers behind a single-outstanding MMIO port.
// Define CLINT_DEBUG_STOP_EN to add the debug_halt input that freezes mtime.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned HART_NUM      = 1,
  parameter int unsigned TIME_DIV_LOG2 = 3,
  parameter logic [63:0] BASE_ADDR     = 64'h0200_0000
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CLINT_DEBUG_STOP_EN
  input  logic                debug_halt,
`endif
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [63:0]         req_addr,
  input  logic [63:0]         req_wdata,
  input  logic [7:0]          req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [63:0]         resp_rdata,
  output logic                resp_err,
  output logic [HART_NUM-1:0] mtip,
  output logic [HART_NUM-1:0] msip,
  output logic [63:0]         mtime_o
);

  state_t              state_q, state_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         cmp_q [HART_NUM];
  logic [63:0]         cmp_d [HART_NUM];
  logic [HART_NUM-1:0] msip_q, msip_d;
  logic [HART_NUM-1:0] mtip_q, mtip_d;

  logic [63:0]         ofs;
  logic [HART_NUM-1:0] hit_msip, hit_cmp;
  logic                hit_mtime, mapped;
  logic [63:0]         rd_val;
  logic                accept, wr, mtime_wr;
  logic                halt, tick;

`ifdef CLINT_DEBUG_STOP_EN
  assign halt = debug_halt;
`else
  assign halt = 1'b0;
`endif

  assign accept   = req_valid & (state_q == StIdle);
  assign wr       = accept & req_we;
  assign mtime_wr = wr & hit_mtime;

  // Exact-match decode; misaligned or out-of-range hart slots fall through as unmapped.
  assign ofs = req_addr - BASE_ADDR;

  always_comb begin
    hit_msip = '0;
    hit_cmp  = '0;
    for (int h = 0; h < int'(HART_NUM); h++) begin
      hit_msip[h] = (ofs == 64'(MSIP_OFS) + 64'(4 * h));
      hit_cmp[h]  = (ofs == 64'(MTIMECMP_OFS) + 64'(8 * h));
    end
    hit_mtime = (ofs == 64'(MTIME_OFS));
    mapped    = (|hit_msip) | (|hit_cmp) | hit_mtime;
  end

  always_comb begin
    rd_val = '0;
    for (int h = 0; h < int'(HART_NUM); h++) begin
      if (hit_msip[h]) rd_val = {63'b0, msip_q[h]};
      if (hit_cmp[h])  rd_val = cmp_q[h];
    end
    if (hit_mtime) rd_val = mtime_q;
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StResp;
          rdata_d = (req_we || !mapped) ? 64'b0 : rd_val;
          err_d   = ~mapped;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  clint_prescaler #(
    .TIME_DIV_LOG2(TIME_DIV_LOG2)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .clear(mtime_wr),
    .tick (tick)
  );

  // A software write to mtime wins over a coincident tick.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_wr) begin
      mtime_d = apply_wstrb(mtime_q, req_wdata, req_wstrb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    msip_d = msip_q;
    for (int h = 0; h < int'(HART_NUM); h++) begin
      cmp_d[h]  = cmp_q[h];
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (wr && hit_msip[h] && req_wstrb[0]) msip_d[h] = req_wdata[0];
      if (wr && hit_cmp[h]) cmp_d[h] = apply_wstrb(cmp_q[h], req_wdata, req_wstrb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mtime_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      for (int h = 0; h < int'(HART_NUM); h++) cmp_q[h] <= MTIMECMP_RST;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mtime_q <= mtime_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      for (int h = 0; h < int'(HART_NUM); h++) cmp_q[h] <= cmp_d[h];
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mtip       = mtip_q;
  assign msip       = msip_q;
  assign mtime_o    = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Randomized bench for clint_timer with a cycle-level behavioural model and directed pins.
module tb_clint_timer;

  localparam int unsigned HARTS = 2;
  localparam logic [63:0] BASE  = 64'h0200_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata, mtime_o;
  logic [1:0]  mtip, msip;
`ifdef CLINT_DEBUG_STOP_EN
  logic        debug_halt = 1'b0;
`endif

  clint_timer #(
    .HART_NUM     (HARTS),
    .TIME_DIV_LOG2(3),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CLINT_DEBUG_STOP_EN
    .debug_halt(debug_halt),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mtip      (mtip),
    .msip      (msip),
    .mtime_o   (mtime_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mtime = value last written + (counting edges since then) / 8.
  logic [63:0] m_anchor;
  int          m_runs;
  logic [63:0] m_cmp [HARTS];
  logic [1:0]  m_msip, m_mtip;
  bit          m_busy, m_err;
  logic [63:0] m_rdata;

  function automatic logic [63:0] m_mtime();
    return m_anchor + 64'(m_runs / 8);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] mask;
    for (int i = 0; i < 64; i++) mask[i] = strb[i / 8];
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_anchor = '0;
    m_runs   = 0;
    for (int h = 0; h < int'(HARTS); h++) m_cmp[h] = ONES;
    m_msip  = '0;
    m_mtip  = '0;
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  // Apply one rising edge's worth of architectural effect to the model.
  task automatic model_edge();
    logic [63:0] mt_old;
    logic [63:0] rd;
    bit          wrote_mtime;
    bit          halted;
    mt_old      = m_mtime();
    wrote_mtime = 1'b0;
    rd          = '0;
`ifdef CLINT_DEBUG_STOP_EN
    halted = debug_halt;
`else
    halted = 1'b0;
`endif
    for (int h = 0; h < int'(HARTS); h++) m_mtip[h] = (mt_old >= m_cmp[h]);
    if (m_busy) begin
      if (resp_ready) m_busy = 1'b0;
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_err  = 1'b1;
      for (int h = 0; h < int'(HARTS); h++) begin
        if (req_addr == BASE + 64'(4 * h)) begin
          m_err = 1'b0;
          rd    = {63'b0, m_msip[h]};
          if (req_we && req_wstrb[0]) m_msip[h] = req_wdata[0];
        end
        if (req_addr == BASE + 64'h4000 + 64'(8 * h)) begin
          m_err = 1'b0;
          rd    = m_cmp[h];
          if (req_we) m_cmp[h] = merge(m_cmp[h], req_wdata, req_wstrb);
        end
      end
      if (req_addr == BASE + 64'hBFF8) begin
        m_err = 1'b0;
        rd    = mt_old;
        if (req_we) begin
          m_anchor    = merge(mt_old, req_wdata, req_wstrb);
          m_runs      = 0;
          wrote_mtime = 1'b1;
        end
      end
      m_rdata = (req_we || m_err) ? 64'b0 : rd;
    end
    if (!wrote_mtime && !halted) m_runs++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  // Single compare process: every outputs against the model, once per cycle.
  always @(negedge clk) begin
    check("req_ready", 64'(req_ready), 64'(!m_busy));
    check("resp_valid", 64'(resp_valid), 64'(m_busy));
    if (m_busy) begin
      check("resp_rdata", resp_rdata, m_rdata);
      check("resp_err", 64'(resp_err), 64'(m_err));
    end
    check("mtime_o", mtime_o, m_mtime());
    check("msip", 64'(msip), 64'(m_msip));
    check("mtip", 64'(mtip), 64'(m_mtip));
  end

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb, input int wait_n);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    cyc();
    for (int i = 0; i < wait_n; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      cyc();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit          found;
    logic [63:0] addr, wdata, mt_hold;
    logic [7:0]  strb;
    int          h;

    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_mtime", mtime_o, 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    check("rst_msip", 64'(msip), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rdata", resp_rdata, 64'd0);

    // mtime after 80 cycles at divide-by-8 is 10.
    repeat (80) cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 64'hBFF8;
    cyc();
    req_valid = 1'b0;
    check("read_mtime_80", resp_rdata, 64'd10);
    check("read_mtime_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;

    // Timer interrupt rises one cycle after mtime reaches mtimecmp.
    issue(1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (mtime_o == 64'd20) found = 1'b1;
    end
    check("mtime_reach20", 64'(found), 64'd1);
    check("mtip_at_20", 64'(mtip[0]), 64'd0);
    cyc();
    check("mtip_after_20", 64'(mtip[0]), 64'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 64'h4000;
    req_wdata = ONES; req_wstrb = 8'hFF; resp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    check("mtip_still_set", 64'(mtip[0]), 64'd1);
    cyc();
    resp_ready = 1'b0;
    check("mtip_cleared", 64'(mtip[0]), 64'd0);

    // mtime write coinciding with a tick wins, then wraps to 0 eight edges later.
    while (m_runs % 8 != 7) cyc();
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 64'hBFF8;
    req_wdata = ONES; req_wstrb = 8'hFF; resp_ready = 1'b1;
    cyc();
    check("mtime_wr_on_tick", mtime_o, ONES);
    req_valid = 1'b0;
    cyc();
    req_valid = 1'b1; req_we = 1'b0;
    cyc();
    check("mtime_readback", resp_rdata, ONES);
    req_valid = 1'b0;
    repeat (6) cyc();
    check("mtime_wrap", mtime_o, 64'd0);
    resp_ready = 1'b0;

    // msip for hart 1, and an all-disabled strobe.
    issue(1'b1, BASE + 64'd4, 64'h1, 8'h0F, 0);
    check("msip_set_h1", 64'(msip), 64'b10);
    issue(1'b1, BASE + 64'd4, 64'h0, 8'h00, 0);
    check("msip_strb0", 64'(msip), 64'b10);

    // Unmapped read with backpressure: response holds still.
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 64'h8000;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("unmapped_err", 64'(resp_err), 64'd1);
      check("unmapped_rdata", resp_rdata, 64'd0);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_resp_valid", 64'(resp_valid), 64'd1);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;

`ifdef CLINT_DEBUG_STOP_EN
    debug_halt = 1'b1;
    mt_hold = m_mtime();
    repeat (100) cyc();
    check("halt_mtime", mtime_o, mt_hold);
    debug_halt = 1'b0;
`endif
    mt_hold = '0;

    // Reset during RESP drops the response and any written state.
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 64'h4008;
    req_wdata = 64'd0; req_wstrb = 8'hFF;
    cyc();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("async_rst_mtime", mtime_o, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      h = int'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: addr = BASE + 64'(4 * h);
        1: addr = BASE + 64'h4000 + 64'(8 * h);
        2: addr = BASE + 64'hBFF8;
        3: addr = BASE + 64'd8;
        4: addr = BASE + 64'h4010;
        5: addr = {$urandom, $urandom};
        6: addr = BASE + 64'h4004;
        default: addr = BASE + 64'h4008;
      endcase
      if ($urandom_range(0, 1) == 1) wdata = m_mtime() + 64'($urandom_range(0, 40));
      else wdata = {$urandom, $urandom};
      strb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
`ifdef CLINT_DEBUG_STOP_EN
      debug_halt = ($urandom_range(0, 3) == 0);
`endif
      issue(1'($urandom_range(0, 1)), addr, wdata, strb, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 The block SHALL have parameter HART_NUM, default 1, number of harts served (1..8).
REQ-002 The block SHALL have parameter TIME_DIV_LOG2, default 3, so mtime advances once every 2^TIME_DIV_LOG2 clocks (0..8).
REQ-003 The block SHALL have parameter BASE_ADDR, default 64'h0200_0000, the CLINT base address.
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port req_valid  input  1  an MMIO request is present.
REQ-007 Port req_ready  output  1  the block accepts a request this cycle.
REQ-008 Port req_we  input  1  1 = write, 0 = read.
REQ-009 Port req_addr  input  64  byte address, 8-byte aligned for mtime/mtimecmp, 4-byte aligned for msip.
REQ-010 Port req_wdata  input  64  write data.
REQ-011 Port req_wstrb  input  8  byte-enable lanes for writes.
REQ-012 Port resp_valid  output  1  a response is present.
REQ-013 Port resp_ready  input  1  the requester takes the response.
REQ-014 Port resp_rdata  output  64  read data; 0 for writes.
REQ-015 Port resp_err  output  1  the address was unmapped.
REQ-016 Port mtip  output  HART_NUM  per-hart timer-interrupt pending.
REQ-017 Port msip  output  HART_NUM  per-hart software-interrupt pending.
REQ-018 Port mtime_o  output  64  current mtime, for the CSR time read.

Function
REQ-019 Address map: msip[h] at BASE+4*h (bit 0 only); mtimecmp[h] at BASE+0x4000+8*h; mtime at BASE+0xBFF8; all other addresses are unmapped.
REQ-020 Handshake FSM: IDLE, then RESP.
- IDLE: req_ready=1, resp_valid=0.
- When req_valid is high, go to RESP.
- RESP: req_ready=0, resp_valid=1.
- When resp_ready is high, return to IDLE.
- Exactly one request is outstanding at a time.
REQ-021 Read latency is one cycle. resp_rdata is the register value at the accept edge. It stays stable while RESP holds.
REQ-022 Writes commit at the accept edge. Only byte lanes with req_wstrb=1 change. msip keeps wdata bit 0 only, and its other bits read 0.
REQ-023 An unmapped access sets resp_err=1 and returns resp_rdata=0. An unmapped write changes no state.
REQ-024 Prescaler counts 0..2^TIME_DIV_LOG2-1. The tick fires on the terminal count, and mtime then increments by 1, wrapping from 2^64-1 to 0. With TIME_DIV_LOG2=0, mtime ticks every cycle.
REQ-025 A write to mtime overrides a same-cycle tick: mtime takes the written value and the prescaler clears to 0.
REQ-026 mtip[h] is registered: it equals (mtime >= mtimecmp[h]) as unsigned, evaluated on the previous cycle's register values.
REQ-027 msip[h] drives directly from its register bit.
REQ-028 mtime_o drives directly from the mtime register.

Reset
REQ-029 Reset SHALL set:
- mtime=0 and prescaler=0;
- every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF;
- msip=0 and mtip=0;
- FSM=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Reset asserted mid-transaction aborts the transaction: the pending response is dropped and no partial write survives after the reset edge.

Configuration
REQ-031 Macro CLINT_DEBUG_STOP_EN, when defined, adds input port debug_halt (1 bit). While debug_halt=1, the prescaler and mtime hold, and MMIO writes to mtime still take effect.
REQ-032 Without CLINT_DEBUG_STOP_EN the debug_halt port is absent and the counter always runs.

Structure
REQ-033 The shared package clint_pkg SHALL hold:
- the offsets MSIP_OFS=0x0, MTIMECMP_OFS=0x4000, MTIME_OFS=0xBFF8;
- the mtimecmp reset constant;
- the FSM state typedef.
REQ-034 Sub-module clint_prescaler SHALL hold the divider counter and its tick/clear/halt logic. The address decode, registers and FSM stay in clint_timer.

Verification
REQ-035 Reset release, then read mtime after 80 cycles with TIME_DIV_LOG2=3 -> resp_rdata=10, one cycle after accept.
REQ-036 Write mtimecmp[0]=20 while mtime is about 10 -> mtip[0]=0 until mtime==20, then mtip[0]=1 one cycle later. Then write mtimecmp[0]=64'hFFFF_FFFF_FFFF_FFFF -> mtip[0]=0 one cycle later.
REQ-037 Write mtime=64'hFFFF_FFFF_FFFF_FFFF on the same edge as a tick -> mtime reads back all-ones. Eight cycles later mtime=0.
REQ-038 HART_NUM=2: write 32'h1 to BASE+4 -> msip=2'b10. Write with req_wstrb=8'h00 -> no change.
REQ-039 Read from BASE+0x8000 -> resp_err=1, resp_rdata=0. Hold resp_ready=0 for 5 cycles -> resp_valid stays 1, req_ready stays 0 and the data is stable.
REQ-040 CLINT_DEBUG_STOP_EN: hold debug_halt=1 for 100 cycles -> mtime unchanged. Assert rst mid-RESP -> resp_valid=0 immediately (asynchronous).
